sync_gen: RTL and testbench

Periodic sync pulse generator that drives the `sync` input of the sample-and-hold, accumulator and other frame-aligned stages in the datapath. It aligns a free-running frame counter to an external timing edge (e.g. PPS) after software arms it. It then emits a sync pulse every PERIOD clocks and reports frame phase and a pulse count for monitoring. Consumers must set their own sampling PERIOD equal to this block's PERIOD.

---
 rtl/sync_gen.sv | 135 +++++++++++++
 tb/tb_sync_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gen.sv
// sync_gen: periodic frame sync generator.
// Aligns a free-running frame counter to a rising edge of ext_sync once armed,
// then issues a PULSE_LEN-wide sync pulse every PERIOD clocks.
// Optional feature: define SYNC_GEN_MISALIGN_CHECK_EN to build the sticky
// misalign detector for external edges that arrive off the frame boundary.
module sync_gen #(
   parameter int PERIOD    = 128,
   parameter int PULSE_LEN = 1,
   parameter int CNT_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ext_sync,
   input  logic                        arm,
   output logic                        sync,
   output logic [$clog2(PERIOD)-1:0]   phase,
   output logic                        armed,
   output logic                        running,
   output logic [CNT_WIDTH-1:0]        sync_count,
   output logic                        misalign
);

   localparam int PW = $clog2(PERIOD);
   localparam logic [PW-1:0] LAST_PHASE = PW'(PERIOD - 1);
   localparam logic [PW-1:0] PULSE_END  = PW'(PULSE_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  ext_d_q, ext_d_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic                  running_q, running_d;
   logic                  armed_q, armed_d;
   logic                  sync_q, sync_d;
   logic [CNT_WIDTH-1:0]  sync_count_q, sync_count_d;

   logic                  ext_edge;
   logic                  advance;
   logic                  wrap;
   logic                  align;
   logic                  arm_take;

   // Next-state logic: edge detect, alignment/arming decisions, frame counter and pulse generation.
   always_comb begin
      ext_d_d      = ext_sync;
      ext_edge     = ext_sync & ~ext_d_q;
      advance      = (state_q == RUN) || ((state_q == ARMED) && running_q);
      wrap         = advance && (phase_q == LAST_PHASE);
      align        = (state_q == ARMED) && ext_edge;
      arm_take     = arm && (state_q != ARMED);

      state_d      = state_q;
      phase_d      = phase_q;
      running_d    = running_q;
      sync_count_d = sync_count_q;

      if (advance) begin
         phase_d = phase_q + PW'(1);
      end

      if (align) begin
         state_d   = RUN;
         phase_d   = '0;
         running_d = 1'b1;
      end else if (arm_take) begin
         state_d = ARMED;
      end

      if (align || wrap) begin
         sync_count_d = sync_count_q + CNT_WIDTH'(1);
      end

      armed_d = (state_d == ARMED);
      sync_d  = running_d && (phase_d < PULSE_END);
   end

   // Single state register for the FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ext_d_q      <= 1'b1;
         phase_q      <= '0;
         running_q    <= 1'b0;
         armed_q      <= 1'b0;
         sync_q       <= 1'b0;
         sync_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ext_d_q      <= ext_d_d;
         phase_q      <= phase_d;
         running_q    <= running_d;
         armed_q      <= armed_d;
         sync_q       <= sync_d;
         sync_count_q <= sync_count_d;
      end
   end

`ifdef SYNC_GEN_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // Sticky misalign flag: set by an off-boundary edge while running, cleared by an accepted arm.
   always_comb begin
      misalign_d = misalign_q;
      if (arm_take) begin
         misalign_d = 1'b0;
      end else if ((state_q == RUN) && ext_edge && (phase_q != LAST_PHASE)) begin
         misalign_d = 1'b1;
      end
   end

   // Misalign flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign sync       = sync_q;
   assign phase      = phase_q;
   assign armed      = armed_q;
   assign running    = running_q;
   assign sync_count = sync_count_q;

endmodule

// File: tb/tb_sync_gen.sv
// tb_sync_gen: table-driven, scoreboarded bench for sync_gen with PERIOD=8, PULSE_LEN=2.
module tb_sync_gen;

   localparam int PER  = 8;
   localparam int PLEN = 2;
   localparam int CW   = 16;
`ifdef SYNC_GEN_MISALIGN_CHECK_EN
   localparam int MIS_EN = 1;
`else
   localparam int MIS_EN = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ext_sync = 1'b0;
   logic          arm = 1'b0;
   logic          sync;
   logic [2:0]    phase;
   logic          armed;
   logic          running;
   logic [CW-1:0] sync_count;
   logic          misalign;

   sync_gen #(.PERIOD(PER), .PULSE_LEN(PLEN), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .ext_sync   (ext_sync),
      .arm        (arm),
      .sync       (sync),
      .phase      (phase),
      .armed      (armed),
      .running    (running),
      .sync_count (sync_count),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      bit arm;
      bit ext;
      int e_sync;
      int e_phase;
      int e_armed;
      int e_running;
      int e_count;
      int e_mis;
   } vec_t;

   typedef struct {
      int s;
      int p;
      int a;
      int r;
      int c;
      int m;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int n_cmp  = 0;
   int n_miss = 0;

   int obs_sync[256];
   int obs_phase[256];
   int obs_armed[256];
   int obs_run[256];
   int obs_count[256];
   int obs_mis[256];

   task automatic seg(input bit r, input bit a, input bit e, input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = '{r, a, e, 0, 0, 0, 0, 0, 0};
         vecs.push_back(v);
      end
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase derived from the absolute cycle of the last alignment.
   task automatic buildExpected();
      bit m_run = 0, m_arm = 0, m_prev = 1, m_mis = 0, m_sync = 0, edge_seen;
      int m_align = 0, m_phase = 0, m_cnt = 0, cur_phase;
      for (int k = 0; k < vecs.size(); k++) begin
         edge_seen = vecs[k].ext && !m_prev;
         if (vecs[k].rst) begin
            m_run = 0; m_arm = 0; m_prev = 1; m_mis = 0;
            m_sync = 0; m_phase = 0; m_cnt = 0;
         end else begin
            m_prev    = vecs[k].ext;
            cur_phase = m_phase;
            if (m_arm && edge_seen) begin
               m_arm   = 0;
               m_run   = 1;
               m_align = k + 1;
            end else if (vecs[k].arm) begin
               if (!m_arm) begin
                  m_arm = 1;
                  m_mis = 0;
               end
            end else if (m_run && !m_arm && edge_seen && cur_phase != PER - 1) begin
               if (MIS_EN == 1) m_mis = 1;
            end
            m_phase = m_run ? ((k + 1 - m_align) % PER) : 0;
            m_sync  = m_run && (m_phase < PLEN);
            if (m_run && m_phase == 0) m_cnt = (m_cnt + 1) % (1 << CW);
         end
         vecs[k].e_sync    = m_sync;
         vecs[k].e_phase   = m_phase;
         vecs[k].e_armed   = m_arm;
         vecs[k].e_running = m_run;
         vecs[k].e_count   = m_cnt;
         vecs[k].e_mis     = m_mis;
      end
   endtask

   task automatic applyStimulus(input int k);
      exp_t e;
      string nm;
      rst      = vecs[k].rst;
      arm      = vecs[k].arm;
      ext_sync = vecs[k].ext;
      sb.push_back('{vecs[k].e_sync, vecs[k].e_phase, vecs[k].e_armed,
                     vecs[k].e_running, vecs[k].e_count, vecs[k].e_mis});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      obs_sync[k+1]  = int'(sync);
      obs_phase[k+1] = int'(phase);
      obs_armed[k+1] = int'(armed);
      obs_run[k+1]   = int'(running);
      obs_count[k+1] = int'(sync_count);
      obs_mis[k+1]   = int'(misalign);
      n_cmp++;
      if (sync !== 1'(e.s) || int'(phase) != e.p || armed !== 1'(e.a) ||
          running !== 1'(e.r) || int'(sync_count) != e.c || misalign !== 1'(e.m)) begin
         n_miss++;
         $display("[TB] FAIL vec%0d: got sync=%b phase=%0d armed=%b run=%b cnt=%0d mis=%b, expected sync=%0d phase=%0d armed=%0d run=%0d cnt=%0d mis=%0d",
                  k, sync, phase, armed, running, sync_count, misalign,
                  e.s, e.p, e.a, e.r, e.c, e.m);
      end
   endtask

   initial begin
      // Main alignment run: arm at 2, edge at 10.
      seg(1,0,0,1); seg(0,0,0,1); seg(0,1,0,1); seg(0,0,0,7);
      seg(0,0,1,4); seg(0,0,0,17);
      // Re-arm from RUN, realign on an edge at phase 5 (cycle 32).
      seg(0,1,0,1); seg(0,0,1,3); seg(0,0,0,9);
      // Unarmed edge at phase 3 (cycle 44), then arm at 48.
      seg(0,0,1,2); seg(0,0,0,2); seg(0,1,0,1); seg(0,0,0,3);
      // Realign at 52, reset at phase 4 (cycle 57), idle with an edge.
      seg(0,0,1,3); seg(0,0,0,2); seg(1,0,0,1); seg(0,0,0,3);
      seg(0,0,1,3); seg(0,0,0,7);
      // ext_sync held high through reset, arm, then a fresh rising edge at 83.
      seg(1,0,1,1); seg(0,0,1,1); seg(0,1,1,1); seg(0,0,1,7);
      seg(0,0,0,2); seg(0,0,1,3); seg(0,0,0,4);
      // arm and edge together from IDLE at 92, aligning edge at 97.
      seg(1,0,0,1); seg(0,0,0,1); seg(0,1,1,1); seg(0,0,1,2);
      seg(0,0,0,2); seg(0,0,1,2); seg(0,0,0,1);
      // Random tail.
      begin
         bit e = 0;
         for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) e = ~e;
            seg(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0), e, 1);
         end
      end
      buildExpected();

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(k);
      end

      for (int c = 11; c <= 30; c++) begin
         checkOutput($sformatf("sync@%0d", c), obs_sync[c],
                     (c == 11 || c == 12 || c == 19 || c == 20 || c == 27 || c == 28) ? 1 : 0);
      end
      checkOutput("phase@11", obs_phase[11], 0);
      checkOutput("phase@19", obs_phase[19], 0);
      checkOutput("phase@27", obs_phase[27], 0);
      checkOutput("count@11", obs_count[11], 1);
      checkOutput("count@19", obs_count[19], 2);
      checkOutput("count@27", obs_count[27], 3);

      checkOutput("armed@32", obs_armed[32], 1);
      checkOutput("realign_phase@33", obs_phase[33], 0);
      checkOutput("realign_sync@33", obs_sync[33], 1);
      checkOutput("old_slot_sync@35", obs_sync[35], 0);
      checkOutput("resume_sync@41", obs_sync[41], 1);
      checkOutput("resume_phase@41", obs_phase[41], 0);
      checkOutput("realign_mis@34", obs_mis[34], 0);

      checkOutput("mis_set@45", obs_mis[45], MIS_EN);
      checkOutput("mis_phase@45", obs_phase[45], 4);
      checkOutput("mis_sticky@48", obs_mis[48], MIS_EN);
      checkOutput("mis_clear@49", obs_mis[49], 0);
      checkOutput("armed@49", obs_armed[49], 1);

      checkOutput("phase@57", obs_phase[57], 4);
      checkOutput("rst_run@58", obs_run[58], 0);
      checkOutput("rst_count@58", obs_count[58], 0);
      for (int c = 58; c <= 71; c++) begin
         checkOutput($sformatf("idle_sync@%0d", c), obs_sync[c], 0);
      end

      checkOutput("held_armed@74", obs_armed[74], 1);
      checkOutput("held_sync@80", obs_sync[80], 0);
      checkOutput("held_run@83", obs_run[83], 0);
      checkOutput("held_sync@84", obs_sync[84], 1);
      checkOutput("held_count@84", obs_count[84], 1);

      checkOutput("both_armed@93", obs_armed[93], 1);
      checkOutput("both_sync@93", obs_sync[93], 0);
      checkOutput("both_run@96", obs_run[96], 0);
      checkOutput("both_sync@98", obs_sync[98], 1);
      checkOutput("both_phase@98", obs_phase[98], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
